// File: rtl/seq_pkg.sv
// Shared types and constants for the control sequencer: FSM states, microstep
// width and flag bit positions.
package seq_pkg;

  typedef enum logic [1:0] {
    PAUSE  = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  localparam int STEP_W = 2;
  localparam logic [STEP_W-1:0] LAST_STEP = 2'd3;

  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/control_sequencer_if.sv
// Control-word / instruction-bus bundle between the control ROM side (master)
// and the sequencer (slave), including the decoded IR fields and flags.
interface control_sequencer_if;
  logic [7:0] bus_in;
  logic       IIn;
  logic       FIn;
  logic       HLT;
  logic       carry_in;
  logic       zero_in;
  logic       ctrl_idle;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [1:0] flags;

  modport master (
    output bus_in, IIn, FIn, HLT, carry_in, zero_in, ctrl_idle,
    input  opcode, operand, flags
  );

  modport slave (
    input  bus_in, IIn, FIn, HLT, carry_in, zero_in, ctrl_idle,
    output opcode, operand, flags
  );
endinterface

// File: rtl/seq_step_counter.sv
// Microstep counter and completed-instruction counter. Optional feature macro:
// SEQ_EARLY_END_EN lets an idle control word end the instruction early.
module seq_step_counter
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              ctrl_idle,
  output logic [STEP_W-1:0] step,
  output logic [7:0]        instr_count
);

  logic early_end;
  logic instr_end;

`ifdef SEQ_EARLY_END_EN
  assign early_end = ctrl_idle && (step != '0);
`else
  logic unused_ctrl_idle;
  assign unused_ctrl_idle = ctrl_idle;
  assign early_end        = 1'b0;
`endif

  assign instr_end = (step == LAST_STEP) || early_end;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step        <= '0;
      instr_count <= '0;
    end else if (en) begin
      step <= instr_end ? '0 : step + STEP_W'(1);
      if (instr_end) begin
        instr_count <= instr_count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Run/step/halt sequencer: gates the datapath clock enable, owns the
// instruction register and flags, and tracks microsteps via seq_step_counter.
module control_sequencer
  import seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                run_mode,
  input  logic                step_req,
  control_sequencer_if.slave  cw,
  output logic [STEP_W-1:0]   step,
  output logic                clk_en,
  output logic                halted,
  output logic [7:0]          instr_count
);

  seq_state_t state;
  logic       step_armed;
  logic       step_edge;
  logic       adv;
  logic [7:0] ir;
  logic [1:0] flags_q;

  // step_armed means "step_req was seen low"; it clears on reset so a level
  // held through reset release never counts as a rising edge.
  assign step_edge = step_req && step_armed;
  assign adv       = (state == RUN) || ((state == PAUSE) && step_edge);
  assign clk_en    = adv && !cw.HLT && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_armed <= 1'b0;
    end else begin
      step_armed <= !step_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= PAUSE;
      halted <= 1'b0;
    end else begin
      case (state)
        PAUSE: begin
          if (adv && cw.HLT) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (run_mode) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (cw.HLT) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (!run_mode) begin
            state <= PAUSE;
          end
        end
        HALTED: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= PAUSE;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir      <= '0;
      flags_q <= '0;
    end else if (clk_en) begin
      if (!cw.IIn) begin
        ir <= cw.bus_in;
      end
      if (!cw.FIn) begin
        flags_q[FLAG_C] <= cw.carry_in;
        flags_q[FLAG_Z] <= cw.zero_in;
      end
    end
  end

  assign cw.opcode  = ir[7:4];
  assign cw.operand = ir[3:0];
  assign cw.flags   = flags_q;

  seq_step_counter u_step_counter (
    .clk         (clk),
    .rst         (rst),
    .en          (clk_en),
    .ctrl_idle   (cw.ctrl_idle),
    .step        (step),
    .instr_count (instr_count)
  );

endmodule
